// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// State encoding is fixed so that busy can be read straight off the state register.
package uart_sched_pkg;

  localparam int ID_W = 3;
  localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker: the first requester with req set,
// searching upward from ptr+1 and wrapping modulo NREQ.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  int cand;

  // The last winner is searched last, which gives every other requester a turn first.
  always_comb begin
    grant = '0;
    id    = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        id          = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART tx FIFO write port among NREQ byte streams, one whole packet per grant,
// optionally prefixing each packet with a channel header byte.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int         NREQ     = 4,
  parameter int         DBIT     = 8,
  parameter int         HDR_EN   = 1,
  parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT,
  parameter int         TMO      = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DBIT-1:0] data,
  input  logic [NREQ-1:0]      last,
  output logic [NREQ-1:0]      ack,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 abort
);

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [NREQ-1:0] sel;
  logic [7:0]      timer;
  logic [7:0]      timer_inc;
  logic [NREQ-1:0] win_grant;
  logic [ID_W-1:0] win_id;
  logic            win_valid;
  logic            req_g;
  logic            last_g;
  logic [DBIT-1:0] data_g;
  logic [DBIT-1:0] hdr_byte;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .id    (win_id),
    .valid (win_valid)
  );

  assign req_g     = |(req & sel);
  assign last_g    = |(last & sel);
  assign hdr_byte  = DBIT'({HDR_BASE[7:3], grant_id});
  assign timer_inc = timer + 8'd1;
  assign busy      = (state != IDLE);

  // Write strobe and data are zero-latency so the FIFO captures on the same edge the state advances.
  always_comb begin
    data_g  = '0;
    wr_uart = 1'b0;
    w_data  = '0;
    ack     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == ID_W'(i)) data_g = data[i*DBIT +: DBIT];
    end
    case (state)
      HDR: begin
        wr_uart = !tx_full;
        w_data  = hdr_byte;
      end
      DATA: begin
        wr_uart = req_g && !tx_full;
        w_data  = data_g;
        if (req_g && !tx_full) ack = sel;
      end
      default: ;
    endcase
  end

  // Back-pressure freezes the timer; only a starved granted requester counts toward abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= ID_W'(NREQ - 1);
      grant_id <= '0;
      sel      <= '0;
      timer    <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant_id <= win_id;
            rr_ptr   <= win_id;
            sel      <= win_grant;
            timer    <= '0;
            state    <= (HDR_EN != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (!tx_full) begin
            timer <= '0;
            state <= DATA;
          end
        end
        DATA: begin
          if (wr_uart) begin
            timer <= '0;
            if (last_g) state <= IDLE;
          end else if (!tx_full) begin
            if (timer_inc == 8'(TMO)) begin
              abort <= 1'b1;
              timer <= '0;
              state <= IDLE;
            end else begin
              timer <= timer_inc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table for a single packet with stall, hand-written
// reset/timeout/hold sequences, and randomized streams checked against a packet-level model.
module tb_uart_tx_scheduler;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int TMO  = 255;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*DBIT-1:0] data = '0;
  logic [NREQ-1:0]      last = '0;
  logic [NREQ-1:0]      ack;
  logic                 tx_full = 1'b0;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic                 busy;
  logic [2:0]           grant_id;
  logic                 abort;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [NREQ-1:0] req;
    logic [7:0]      d0;
    logic [NREQ-1:0] last;
    logic            full;
    int              reps;
    logic            exp_wr;
    logic [7:0]      exp_wd;
    logic [NREQ-1:0] exp_ack;
    logic            exp_busy;
  } vec_t;

  vec_t tbl [8];

  logic [7:0] pdat  [NREQ][32];
  logic       plast [NREQ][32];
  int         cnt   [NREQ];
  int         rd    [NREQ];
  int         start [NREQ];
  int         data_bytes;
  logic [7:0] exp_q [$];

  always #10 clk = ~clk;

  uart_tx_scheduler #(
    .NREQ(NREQ), .DBIT(DBIT), .HDR_EN(1), .HDR_BASE(8'hA0), .TMO(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .data     (data),
    .last     (last),
    .ack      (ack),
    .tx_full  (tx_full),
    .wr_uart  (wr_uart),
    .w_data   (w_data),
    .busy     (busy),
    .grant_id (grant_id),
    .abort    (abort)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    req     = '0;
    last    = '0;
    data    = '0;
    tx_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic apply_stimulus(input logic [NREQ-1:0] r, input logic [7:0] d0,
                                input logic [NREQ-1:0] l, input logic f);
    req               = r;
    data[DBIT-1:0]    = d0;
    last              = l;
    tx_full           = f;
  endtask

  task automatic clear_streams();
    for (int i = 0; i < NREQ; i++) begin
      cnt[i]   = 0;
      start[i] = 0;
    end
    data_bytes = 0;
    exp_q      = {};
  endtask

  task automatic add_byte(input int i, input logic [7:0] b, input logic is_last);
    pdat[i][cnt[i]]  = b;
    plast[i][cnt[i]] = is_last;
    cnt[i]++;
    data_bytes++;
  endtask

  // Reference: with every requester ready at each arbitration point, packets leave in
  // plain cyclic order 0,1,2,3,... skipping requesters that have run out of packets.
  task automatic build_expected();
    int  pos [NREQ];
    bool_loop: begin end
    for (int i = 0; i < NREQ; i++) pos[i] = 0;
    for (int round = 0; round < 64; round++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pos[i] < cnt[i]) begin
          exp_q.push_back(8'hA0 | 8'(i));
          while (pos[i] < cnt[i]) begin
            exp_q.push_back(pdat[i][pos[i]]);
            pos[i]++;
            if (plast[i][pos[i]-1]) break;
          end
        end
      end
    end
  endtask

  task automatic run_streams(input bit noisy, input int budget);
    int   acks;
    int   aborts;
    bit   done;
    logic first;
    bit   active;
    bit   hole;
    acks   = 0;
    aborts = 0;
    done   = 1'b0;
    for (int i = 0; i < NREQ; i++) rd[i] = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        first = 1'b1;
        if (rd[i] > 0) first = plast[i][rd[i]-1];
        active = (c >= start[i]) && (rd[i] < cnt[i]);
        hole   = noisy && !first && ($urandom_range(3) == 0);
        req[i] = active && !hole;
        data[i*DBIT +: DBIT] = active ? pdat[i][rd[i]] : 8'($urandom);
        last[i] = (active && !hole) ? plast[i][rd[i]] : 1'($urandom);
      end
      tx_full = noisy && ($urandom_range(3) == 0);
      @(negedge clk);
      if (wr_uart) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL stream_extra: got write 0x%0h, expected no write", w_data);
        end else begin
          check_output("stream_byte", 32'(w_data), 32'(exp_q.pop_front()));
        end
      end
      if (ack != '0) begin
        check_output("ack_onehot", 32'($countones(ack)), 32'd1);
        for (int i = 0; i < NREQ; i++) if (ack[i]) rd[i]++;
        acks++;
      end
      if (abort) aborts++;
      done = (exp_q.size() == 0);
      for (int i = 0; i < NREQ; i++) if (rd[i] != cnt[i]) done = 1'b0;
    end
    check_output("stream_drained", 32'(exp_q.size()), 32'd0);
    check_output("stream_acks", 32'(acks), 32'(data_bytes));
    check_output("stream_no_abort", 32'(aborts), 32'd0);
  endtask

  initial begin
    int k;
    int wr_seen;
    int ack_seen;

    tbl[0] = '{4'b0001, 8'h11, 4'b0000, 1'b0, 1,  1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[1] = '{4'b0001, 8'h11, 4'b0000, 1'b0, 1,  1'b1, 8'hA0, 4'b0000, 1'b1};
    tbl[2] = '{4'b0001, 8'h11, 4'b0000, 1'b0, 1,  1'b1, 8'h11, 4'b0001, 1'b1};
    tbl[3] = '{4'b0001, 8'h22, 4'b0000, 1'b1, 20, 1'b0, 8'h22, 4'b0000, 1'b1};
    tbl[4] = '{4'b0001, 8'h22, 4'b0000, 1'b0, 1,  1'b1, 8'h22, 4'b0001, 1'b1};
    tbl[5] = '{4'b0001, 8'h33, 4'b0001, 1'b0, 1,  1'b1, 8'h33, 4'b0001, 1'b1};
    tbl[6] = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1,  1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[7] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 2,  1'b0, 8'h00, 4'b0000, 1'b0};

    // Reset with garbage inputs, then an asynchronous reset landing mid-packet.
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      req     = 4'($urandom);
      last    = 4'($urandom);
      data    = 32'($urandom);
      tx_full = 1'($urandom);
      @(negedge clk);
      check_output("reset_state", {17'd0, wr_uart, ack, busy, grant_id, abort, w_data}, 32'd0);
    end
    do_reset();
    @(posedge clk);
    #1;
    apply_stimulus(4'b0001, 8'h5A, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_output("async_reset", {26'd0, wr_uart, ack, busy}, 32'd0);

    // Single packet 11,22,33 with a 20-cycle stall in the middle.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      for (int r = 0; r < tbl[n].reps; r++) begin
        @(posedge clk);
        #1;
        apply_stimulus(tbl[n].req, tbl[n].d0, tbl[n].last, tbl[n].full);
        @(negedge clk);
        check_output($sformatf("vec%0d", n), {17'd0, wr_uart, w_data, ack, busy, abort},
                     {17'd0, tbl[n].exp_wr, tbl[n].exp_wd, tbl[n].exp_ack, tbl[n].exp_busy, 1'b0});
      end
    end

    // Round-robin of one-byte packets from every requester.
    do_reset();
    clear_streams();
    for (int i = 0; i < NREQ; i++) begin
      add_byte(i, 8'h10 + 8'(i), 1'b1);
      add_byte(i, 8'h20 + 8'(i), 1'b1);
    end
    build_expected();
    run_streams(1'b0, 200);

    // Timeout: requester 2 stalls after one byte while requester 3 waits.
    do_reset();
    @(posedge clk);
    #1;
    req = 4'b0100;
    data[2*DBIT +: DBIT] = 8'h77;
    last = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    check_output("tmo_header", {23'd0, wr_uart, w_data}, {23'd0, 1'b1, 8'hA2});
    @(posedge clk);
    @(negedge clk);
    check_output("tmo_byte", {19'd0, wr_uart, w_data, ack}, {19'd0, 1'b1, 8'h77, 4'b0100});
    @(posedge clk);
    #1;
    req  = 4'b1000;
    last = 4'b1000;
    data[3*DBIT +: DBIT] = 8'h88;
    k        = 0;
    wr_seen  = 0;
    ack_seen = 0;
    for (int c = 1; c <= TMO + 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (abort) begin
        k = c;
        break;
      end
      if (wr_uart) wr_seen++;
      if (ack != '0) ack_seen++;
    end
    check_output("tmo_cycles", 32'(k), 32'(TMO));
    check_output("tmo_busy", {31'd0, busy}, 32'd0);
    check_output("tmo_quiet", 32'(wr_seen + ack_seen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("tmo_next_grant", {22'd0, abort, wr_uart, w_data}, {22'd0, 1'b0, 1'b1, 8'hA3});

    // Packet hold: requester 1 keeps the grant for all four bytes although 0 starts asking.
    do_reset();
    clear_streams();
    add_byte(1, 8'h51, 1'b0);
    add_byte(1, 8'h52, 1'b0);
    add_byte(1, 8'h53, 1'b0);
    add_byte(1, 8'h54, 1'b1);
    add_byte(0, 8'h60, 1'b1);
    start[0] = 2;
    exp_q = '{8'hA1, 8'h51, 8'h52, 8'h53, 8'h54, 8'hA0, 8'h60};
    run_streams(1'b0, 200);

    // Randomized streams with holes and back-pressure.
    for (int s = 0; s < 4; s++) begin
      do_reset();
      clear_streams();
      for (int i = 0; i < NREQ; i++) begin
        int npk;
        npk = (i == 0) ? $urandom_range(3, 1) : $urandom_range(3, 0);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1);
        end
      end
      build_expected();
      run_streams(1'b1, 3000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
